// File: rtl/bus_pkg.sv
// bus_pkg: shared BUS layout, arbiter state encoding and beat-count helper.
package bus_pkg;
  localparam int BUS_W     = 73;
  localparam int VALID_BIT = 0;
  localparam int PADR_LSB  = 1;
  localparam int PADR_MSB  = 15;
  localparam int DATA_LSB  = 16;
  localparam int DATA_MSB  = 47;
  localparam int RET_LSB   = 48;
  localparam int RET_MSB   = 51;
  localparam int DEST_LSB  = 52;
  localparam int DEST_MSB  = 55;
  localparam int RW_BIT    = 56;
  localparam int SIZE_LSB  = 57;
  localparam int SIZE_MSB  = 72;
  localparam int MAX_BEATS = 4;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_RELEASE} arb_state_e;
  // A zero-beat request still moves one beat; long bursts are capped.
  function automatic logic [2:0] sat_beats(input logic [2:0] b);
    return (b == 3'd0) ? 3'd1 : (b > 3'(MAX_BEATS)) ? 3'(MAX_BEATS) : b;
  endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester/arbiter handshake bundle with master and slave views.
interface bus_arbiter_if #(parameter int NUM_REQ = 4) ();
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*4-1:0] req_dest;
  logic [NUM_REQ*3-1:0] req_beats;
  logic [15:0]          dest_free;
  logic [NUM_REQ-1:0]   gnt;
  logic [15:0]          set_receiver;
  logic                 bus_busy;
  logic [2:0]           beats_left;
  logic [NUM_REQ-1:0]   done;
  logic                 arb_timeout;
  modport master (
    output req, req_dest, req_beats, dest_free,
    input  gnt, set_receiver, bus_busy, beats_left, done, arb_timeout
  );
  modport slave (
    input  req, req_dest, req_beats, dest_free,
    output gnt, set_receiver, bus_busy, beats_left, done, arb_timeout
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first eligible bit at or after ptr_i.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic          valid_o
);
  logic [PW-1:0] idx;
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!valid_o && elig_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter IDLE/SETUP/XFER/RELEASE; BUS_ARB_TIMEOUT_EN adds a starvation timeout.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TMO_CYC = 32
) (
  input logic          clk_bus,
  input logic          rst,
  bus_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  arb_state_e         state_q;
  logic [NUM_REQ-1:0] elig, win, gnt_q, done_q;
  logic               win_vld, busy_q;
  logic [PW-1:0]      ptr_q, ptr_d, gnt_idx_q, win_idx;
  logic [3:0]         win_dest;
  logic [2:0]         win_beats, beats_left_q;
  logic [15:0]        set_rx_q;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign elig[i] = bus.req[i] & bus.dest_free[bus.req_dest[4*i +: 4]];
  end
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .win_o  (win),
    .valid_o(win_vld)
  );
  always_comb begin
    win_idx   = '0;
    win_dest  = '0;
    win_beats = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) begin
        win_idx   = PW'(i);
        win_dest  = bus.req_dest[4*i +: 4];
        win_beats = bus.req_beats[3*i +: 3];
      end
    ptr_d = (gnt_idx_q == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
  end
  // Destination and beat count are captured only at grant; later input changes are ignored.
  always_ff @(posedge clk_bus or negedge rst)
    if (!rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      ptr_q        <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      set_rx_q     <= '0;
      beats_left_q <= '0;
    end else
      case (state_q)
        S_IDLE:
          if (win_vld) begin
            state_q      <= S_SETUP;
            gnt_q        <= win;
            gnt_idx_q    <= win_idx;
            busy_q       <= 1'b1;
            set_rx_q     <= 16'h1 << win_dest;
            beats_left_q <= sat_beats(win_beats);
          end
        S_SETUP: begin
          state_q  <= S_XFER;
          set_rx_q <= '0;
        end
        S_XFER:
          if (beats_left_q == 3'd1) begin
            state_q      <= S_RELEASE;
            gnt_q        <= '0;
            done_q       <= gnt_q;
            ptr_q        <= ptr_d;
            beats_left_q <= '0;
          end else
            beats_left_q <= beats_left_q - 3'd1;
        S_RELEASE: begin
          state_q <= S_IDLE;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.bus_busy     = busy_q;
  assign bus.set_receiver = set_rx_q;
  assign bus.beats_left   = beats_left_q;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_pulse_q;
  logic          starve;
  assign starve = (state_q == S_IDLE) && (|bus.req) && !win_vld;
  always_ff @(posedge clk_bus or negedge rst)
    if (!rst) begin
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_pulse_q <= starve && (tmo_q == TW'(TMO_CYC - 1));
      tmo_q       <= (!starve || tmo_q == TW'(TMO_CYC - 1)) ? '0 : tmo_q + 1'b1;
    end
  assign bus.arb_timeout = tmo_pulse_q;
`else
  // TMO_CYC only shapes the optional timeout; the term below is always 0.
  assign bus.arb_timeout = 1'b0 & (TMO_CYC < 0);
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (BUS_ARB_TIMEOUT_EN selects timeout checks).
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  bus_arbiter_if #(.NUM_REQ(4)) bus ();
  bus_arbiter #(.NUM_REQ(4), .TMO_CYC(32)) dut (
    .clk_bus(clk),
    .rst    (rst_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_idle_outs(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
    check({tag, "_setrx"}, 32'(bus.set_receiver), 32'h0);
    check({tag, "_busy"}, 32'(bus.bus_busy), 32'h0);
    check({tag, "_bl"}, 32'(bus.beats_left), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
  endtask
  // Expects a grant on the next edge, then follows SETUP, XFER and RELEASE.
  task automatic xfer(input string tag, input logic [3:0] eg, input logic [15:0] es,
                      input int eb, input bit drop);
    int w, n;
    w = 0;
    tick();
    while (bus.gnt == 4'h0 && w < 8) begin
      w++;
      tick();
    end
    check({tag, "_wait"}, 32'(w), 32'd0);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
    check({tag, "_setrx"}, 32'(bus.set_receiver), 32'(es));
    check({tag, "_bl"}, 32'(bus.beats_left), 32'(eb));
    check({tag, "_busy"}, 32'(bus.bus_busy), 32'd1);
    if (drop) bus.req = bus.req & ~bus.gnt;
    n = 0;
    tick();
    while (bus.gnt != 4'h0 && n < 8) begin
      check({tag, "_hold"}, 32'(bus.gnt), 32'(eg));
      check({tag, "_setrx0"}, 32'(bus.set_receiver), 32'h0);
      n++;
      tick();
    end
    check({tag, "_xfer"}, 32'(n), 32'(eb));
    check({tag, "_done"}, 32'(bus.done), 32'(eg));
    check({tag, "_relbusy"}, 32'(bus.bus_busy), 32'd1);
    tick();
    check({tag, "_idlebusy"}, 32'(bus.bus_busy), 32'd0);
    check({tag, "_idledone"}, 32'(bus.done), 32'h0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    int np, p1, p2;
    bus.req       = 4'h0;
    bus.req_dest  = '0;
    bus.req_beats = '0;
    bus.dest_free = 16'hFFFF;
    #2 rst_n = 1'b0;
    bus.req      = 4'b0001;
    bus.req_dest = {4'd0, 4'd0, 4'd0, 4'd3};
    tick();
    tick();
    check_idle_outs("rst");
    check("rst_tmo", 32'(bus.arb_timeout), 32'd0);
    rst_n = 1'b1;
    bus.req_beats = {3'd1, 3'd1, 3'd1, 3'd4};
    xfer("single", 4'b0001, 16'h0008, 4, 1'b1);
    do_reset();
    bus.req       = 4'b1111;
    bus.req_dest  = {4'd3, 4'd2, 4'd1, 4'd0};
    bus.req_beats = {3'd1, 3'd1, 3'd1, 3'd1};
    xfer("fair0", 4'b0001, 16'h0001, 1, 1'b0);
    xfer("fair1", 4'b0010, 16'h0002, 1, 1'b0);
    xfer("fair2", 4'b0100, 16'h0004, 1, 1'b0);
    xfer("fair3", 4'b1000, 16'h0008, 1, 1'b0);
    xfer("fair4", 4'b0001, 16'h0001, 1, 1'b0);
    bus.req = 4'h0;
    tick();
    do_reset();
    bus.req       = 4'b0011;
    bus.req_dest  = {4'd0, 4'd0, 4'd1, 4'd5};
    bus.dest_free = 16'hFFDF;
    xfer("blk1", 4'b0010, 16'h0002, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("blk_wait_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.dest_free = 16'hFFFF;
    xfer("blk0", 4'b0001, 16'h0020, 1, 1'b1);
    bus.req       = 4'b0001;
    bus.req_dest  = {4'd0, 4'd0, 4'd0, 4'd2};
    bus.req_beats = {3'd1, 3'd1, 3'd1, 3'd0};
    xfer("beats0", 4'b0001, 16'h0004, 1, 1'b1);
    bus.req       = 4'b0001;
    bus.req_beats = {3'd1, 3'd1, 3'd1, 3'd7};
    xfer("beats7", 4'b0001, 16'h0004, 4, 1'b1);
    bus.req       = 4'b0001;
    bus.req_dest  = {4'd0, 4'd0, 4'd0, 4'd0};
    bus.req_beats = {3'd1, 3'd1, 3'd1, 3'd4};
    tick();
    tick();
    tick();
    tick();
    check("mid_bl", 32'(bus.beats_left), 32'd2);
    bus.req = 4'h0;
    #1 rst_n = 1'b0;
    #1 check_idle_outs("midrst");
    tick();
    check("midrst_done", 32'(bus.done), 32'h0);
    tick();
    check("midrst_done2", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_busy", 32'(bus.bus_busy), 32'd0);
    bus.req = 4'b0001;
    xfer("post", 4'b0001, 16'h0001, 4, 1'b1);
    bus.req       = 4'b0001;
    bus.req_dest  = {4'd0, 4'd0, 4'd0, 4'd5};
    bus.dest_free = 16'hFFDF;
    np = 0;
    p1 = 0;
    p2 = 0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (bus.arb_timeout) begin
        np++;
        if (np == 1) p1 = c;
        if (np == 2) p2 = c;
      end
    end
`ifdef BUS_ARB_TIMEOUT_EN
    check("tmo_count", 32'(np), 32'd2);
    check("tmo_first", 32'(p1), 32'd32);
    check("tmo_second", 32'(p2), 32'd64);
`else
    check("tmo_count", 32'(np), 32'd0);
    check("tmo_first", 32'(p1), 32'd0);
`endif
    check("tmo_gnt", 32'(bus.gnt), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
